pattern_hflipper: RTL and testbench



---
 rtl/gpu_pkg.sv | 19 +
 rtl/pattern_hflipper_pixel_reverse.sv | 31 +++
 rtl/pattern_hflipper.sv | 81 ++++++++
 tb/tb_pattern_hflipper.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// ============================================================================
// Module      : gpu_pkg
// Description : Shared types and defaults for the foreground pattern path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

  // Default pattern line geometry: eight 2-bit pixels per line
  localparam int PATTERN_PIXELS = 8;
  localparam int PATTERN_BPP    = 2;

  typedef logic [PATTERN_PIXELS*PATTERN_BPP-1:0] pattern_line_t;
  typedef logic [PATTERN_BPP-1:0]                pixel_t;

endpackage

`default_nettype wire

// File: rtl/pattern_hflipper_pixel_reverse.sv
// ============================================================================
// Module      : pixel_reverse
// Description : Combinational pixel-field reversal. Each BPP-bit field moves
//               as a unit, so the bit order inside a pixel is preserved.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_reverse #(
  parameter int PIXELS = 8,
  parameter int BPP    = 2
) (
  input  logic [PIXELS*BPP-1:0] line_in,
  input  logic                  sel,
  output logic [PIXELS*BPP-1:0] line_out
);

  logic [PIXELS*BPP-1:0] reversed;

  // Field k of the result takes field (PIXELS-1-k) of the input
  generate
    for (genvar k = 0; k < PIXELS; k++) begin : g_pix
      assign reversed[k*BPP +: BPP] = line_in[(PIXELS-1-k)*BPP +: BPP];
    end
  endgenerate

  assign line_out = sel ? reversed : line_in;

endmodule

`default_nettype wire

// File: rtl/pattern_hflipper.sv
// ============================================================================
// Module      : pattern_hflipper
// Description : Registered horizontal flipper for one foreground pattern line.
//               Latency 1 cycle, 1 line/cycle, no backpressure.
//               Optional macro PATTERN_HFLIPPER_OPAQUE_EN adds a registered
//               per-pixel non-transparent flag output (opaque).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_hflipper
  import gpu_pkg::*;
#(
  parameter int PIXELS = PATTERN_PIXELS,
  parameter int BPP    = PATTERN_BPP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXELS*BPP-1:0] pattern,
  input  logic                  hflip,
  input  logic                  in_valid,
  output logic [PIXELS*BPP-1:0] line,
  output logic                  out_valid
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
  ,
  output logic [PIXELS-1:0]     opaque
`endif
);

  logic [PIXELS*BPP-1:0] line_next;

  pixel_reverse #(
    .PIXELS (PIXELS),
    .BPP    (BPP)
  ) u_pixel_reverse (
    .line_in  (pattern),
    .sel      (hflip),
    .line_out (line_next)
  );

  // Line register loads on a qualified input and holds through gaps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else if (in_valid) begin
      line <= line_next;
    end
  end

  // Valid is a plain one-cycle delay of in_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

`ifdef PATTERN_HFLIPPER_OPAQUE_EN
  logic [PIXELS-1:0] opaque_next;

  // Bit k flags output field k; MSB therefore corresponds to leftmost pixel
  generate
    for (genvar k = 0; k < PIXELS; k++) begin : g_opaque
      assign opaque_next[k] = |line_next[k*BPP +: BPP];
    end
  endgenerate

  // Opaque flags register alongside the line with the same enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opaque <= '0;
    end else if (in_valid) begin
      opaque <= opaque_next;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_hflipper.sv
// ============================================================================
// Module      : tb_pattern_hflipper
// Description : Directed self-checking bench for pattern_hflipper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_hflipper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pattern = '0;
  logic        hflip = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] line;
  logic        out_valid;
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
  logic [7:0]  opaque;
`endif

  int checks   = 0;
  int failures = 0;

  pattern_hflipper dut (
    .clk       (clk),
    .rst       (rst),
    .pattern   (pattern),
    .hflip     (hflip),
    .in_valid  (in_valid),
    .line      (line),
    .out_valid (out_valid)
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
    ,
    .opaque    (opaque)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample just after the next rising edge
  task automatic drive(input logic [15:0] p, input logic h, input logic v);
    @(negedge clk);
    pattern  = p;
    hflip    = h;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: pixel j of result = pixel 7-j of source
  function automatic logic [15:0] ref_flip(input logic [15:0] p);
    logic [15:0] r;
    for (int j = 0; j < 8; j++) begin
      r[15-2*j -: 2] = p[15-2*(7-j) -: 2];
    end
    return r;
  endfunction

  logic [15:0] exp_line;
  logic [15:0] p;
  logic [15:0] r;

  initial begin
    // Reset held with random activity on the inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(16'($urandom()), 1'($urandom()), 1'b1);
      check("rst_line", line, 16'h0000);
      check("rst_valid", 16'(out_valid), 16'h0001 & 16'h0000);
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
      check("rst_opaque", 16'(opaque), 16'h0000);
`endif
    end

    // Release reset, first qualified input appears one edge later
    @(negedge clk);
    rst = 1'b1;
    drive(16'hFFFB, 1'b0, 1'b1);
    check("noflip_valid", 16'(out_valid), 16'h0001);
    check("noflip_line", line, 16'hFFFB);
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
    check("noflip_opaque", 16'(opaque), 16'h00FF);
`endif

    drive(16'b11_00_00_00_10_10_10_11, 1'b1, 1'b1);
    check("flip_line", line, 16'b11_10_10_10_00_00_00_11);
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
    check("flip_opaque", 16'(opaque), 16'b1111_0001);
`endif

    drive(16'b01_00_00_00_00_00_00_10, 1'b1, 1'b1);
    check("bitorder_line", line, 16'b10_00_00_00_00_00_00_01);
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
    check("bitorder_opaque", 16'(opaque), 16'b1000_0001);
`endif

    // Alternating valid: gaps must hold the last loaded line
    drive(16'hA5C3, 1'b0, 1'b1);
    check("hold0_valid", 16'(out_valid), 16'h0001);
    check("hold0_line", line, 16'hA5C3);
    drive(16'h0F0F, 1'b1, 1'b0);
    check("hold1_valid", 16'(out_valid), 16'h0000);
    check("hold1_line", line, 16'hA5C3);
    drive(16'h1234, 1'b1, 1'b1);
    check("hold2_valid", 16'(out_valid), 16'h0001);
    check("hold2_line", line, 16'h1C84);
    drive(16'hFFFF, 1'b0, 1'b0);
    check("hold3_valid", 16'(out_valid), 16'h0000);
    check("hold3_line", line, 16'h1C84);
    drive(16'h8001, 1'b0, 1'b1);
    check("hold4_valid", 16'(out_valid), 16'h0001);
    check("hold4_line", line, 16'h8001);
    drive(16'h7777, 1'b1, 1'b0);
    check("hold5_valid", 16'(out_valid), 16'h0000);
    check("hold5_line", line, 16'h8001);

    // Asynchronous reset mid-stream clears outputs without a clock edge
    drive(16'hBEEF, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_line", line, 16'h0000);
    check("async_valid", 16'(out_valid), 16'h0000);
`ifdef PATTERN_HFLIPPER_OPAQUE_EN
    check("async_opaque", 16'(opaque), 16'h0000);
`endif
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_idle_valid", 16'(out_valid), 16'h0000);
    check("postrst_idle_line", line, 16'h0000);
    drive(16'h4321, 1'b0, 1'b1);
    check("postrst_valid", 16'(out_valid), 16'h0001);
    check("postrst_line", line, 16'h4321);

    // Involution sweep against an independent reference
    for (int i = 0; i < 1000; i++) begin
      p = 16'($urandom());
      drive(p, 1'b1, 1'b1);
      exp_line = ref_flip(p);
      check("sweep_flip", line, exp_line);
      r = line;
      drive(r, 1'b1, 1'b1);
      check("sweep_twice", line, p);
      drive(p, 1'b0, 1'b1);
      check("sweep_plain", line, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
